// File: rtl/ov2640_capture_ctrl_if.sv
// Control, sensor-sync and core-monitor signals shared between the capture
// sequencer (slave) and the register block / capture core side (master).
interface ov2640_capture_ctrl_if;
   logic        cfg_start;
   logic        cfg_continuous;
   logic        cfg_stop;
   logic [3:0]  cfg_skip;
   logic        VSYNC;
   logic        core_enable;
   logic        core_busy;
   logic        mon_tvalid;
   logic        mon_tlast;
   logic        mon_tuser;
   logic        run_active;
   logic        frame_done;
   logic        frame_err;
   logic        timeout;
   logic [15:0] frame_cnt;

   modport master (
      output cfg_start, cfg_continuous, cfg_stop, cfg_skip, VSYNC,
             core_busy, mon_tvalid, mon_tlast, mon_tuser,
      input  core_enable, run_active, frame_done, frame_err, timeout, frame_cnt
   );

   modport slave (
      input  cfg_start, cfg_continuous, cfg_stop, cfg_skip, VSYNC,
             core_busy, mon_tvalid, mon_tlast, mon_tuser,
      output core_enable, run_active, frame_done, frame_err, timeout, frame_cnt
   );
endinterface

// File: rtl/ov2640_capture_ctrl.sv
// Capture sequencer for the OV2640 core: arms the core for single or free-running
// frames with decimation, checks stream geometry and guards against stalled sensors.
module ov2640_capture_ctrl #(
   parameter int IMAGE_HEIGHT   = 300,
   parameter int LINE_BYTES     = 800,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic                  PCLK,
   input  logic                  RESETB,
   ov2640_capture_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_t;

   localparam int              WDW          = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDW-1:0]  WD_LAST      = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0]     LINE_BYTES_W = 17'(LINE_BYTES);
   localparam logic [16:0]     HEIGHT_W     = 17'(IMAGE_HEIGHT);

   state_t          state_reg;
   logic            cont_reg;
   logic [3:0]      skip_cnt_reg;
   logic            vsync_q;
   logic [15:0]     beat_cnt_reg;
   logic [15:0]     line_cnt_reg;
   logic            bad_reg;
   logic [WDW-1:0]  wdog_reg;
   logic            run_active_reg;
   logic            frame_done_reg;
   logic            frame_err_reg;
   logic            timeout_reg;
   logic [15:0]     frame_cnt_reg;

   logic            vs_rise;
   logic            line_end;
   logic            frame_end;
   logic [16:0]     beat_sum;
   logic [16:0]     line_sum;
   logic            bad_now;
   logic            armed;
   logic            wdog_hit;

   assign vs_rise   = bus.VSYNC & ~vsync_q;
   assign line_end  = bus.mon_tvalid & bus.mon_tlast;
   assign frame_end = bus.mon_tvalid & bus.mon_tuser;
   // Sums are one bit wider so a saturated counter can never alias a legal size.
   assign beat_sum  = {1'b0, beat_cnt_reg} + 17'd1;
   assign line_sum  = {1'b0, line_cnt_reg} + 17'd1;
   assign bad_now   = bad_reg
                    | (line_end  & (beat_sum != LINE_BYTES_W))
                    | (line_end  & (line_cnt_reg == 16'hFFFF))
                    | (frame_end & (line_sum != HEIGHT_W));
   assign armed     = (state_reg == S_ARM) || (state_reg == S_CAP);
   assign wdog_hit  = armed && (wdog_reg == WD_LAST);

   assign bus.core_enable = (state_reg == S_ARM) && (skip_cnt_reg == 4'd0);
   assign bus.run_active  = run_active_reg;
   assign bus.frame_done  = frame_done_reg;
   assign bus.frame_err   = frame_err_reg;
   assign bus.timeout     = timeout_reg;
   assign bus.frame_cnt   = frame_cnt_reg;

   always_ff @(posedge PCLK) begin
      if (!RESETB) begin
         state_reg      <= S_IDLE;
         cont_reg       <= 1'b0;
         skip_cnt_reg   <= 4'd0;
         vsync_q        <= 1'b0;
         beat_cnt_reg   <= 16'd0;
         line_cnt_reg   <= 16'd0;
         bad_reg        <= 1'b0;
         wdog_reg       <= '0;
         run_active_reg <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         timeout_reg    <= 1'b0;
         frame_cnt_reg  <= 16'd0;
      end else begin
         vsync_q        <= bus.VSYNC;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         timeout_reg    <= 1'b0;
         if (!armed || vs_rise || bus.mon_tvalid)
            wdog_reg <= '0;
         else
            wdog_reg <= wdog_reg + 1'b1;

         case (state_reg)
            S_IDLE: begin
               if (bus.cfg_start && !bus.core_busy) begin
                  state_reg      <= S_ARM;
                  run_active_reg <= 1'b1;
                  cont_reg       <= bus.cfg_continuous;
                  skip_cnt_reg   <= bus.cfg_skip;
               end
            end
            S_ARM: begin
               if (wdog_hit) begin
                  state_reg      <= S_IDLE;
                  run_active_reg <= 1'b0;
                  cont_reg       <= 1'b0;
                  timeout_reg    <= 1'b1;
               end else if (bus.core_busy) begin
                  // Core already grabbed the frame; a stop here just ends the run after it.
                  state_reg    <= S_CAP;
                  beat_cnt_reg <= 16'd0;
                  line_cnt_reg <= 16'd0;
                  wdog_reg     <= '0;
                  if (bus.cfg_stop) cont_reg <= 1'b0;
               end else if (bus.cfg_stop) begin
                  state_reg      <= S_IDLE;
                  run_active_reg <= 1'b0;
               end else if (vs_rise && (skip_cnt_reg != 4'd0)) begin
                  skip_cnt_reg <= skip_cnt_reg - 4'd1;
               end
            end
            S_CAP: begin
               if (wdog_hit) begin
                  state_reg      <= S_IDLE;
                  run_active_reg <= 1'b0;
                  cont_reg       <= 1'b0;
                  timeout_reg    <= 1'b1;
                  bad_reg        <= 1'b0;
               end else begin
                  if (bus.mon_tvalid) begin
                     if (bus.mon_tlast) begin
                        beat_cnt_reg <= 16'd0;
                        if (line_cnt_reg != 16'hFFFF) line_cnt_reg <= line_cnt_reg + 16'd1;
                     end else if (beat_cnt_reg != 16'hFFFF) begin
                        beat_cnt_reg <= beat_cnt_reg + 16'd1;
                     end
                  end
                  bad_reg <= bad_now;
                  if (bus.cfg_stop) cont_reg <= 1'b0;
                  if (!bus.core_busy) begin
                     state_reg      <= S_DONE;
                     wdog_reg       <= '0;
                     frame_done_reg <= 1'b1;
                     frame_err_reg  <= bad_now;
                     frame_cnt_reg  <= frame_cnt_reg + 16'd1;
                     bad_reg        <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (cont_reg && !bus.cfg_stop) begin
                  state_reg    <= S_ARM;
                  skip_cnt_reg <= bus.cfg_skip;
               end else begin
                  state_reg      <= S_IDLE;
                  run_active_reg <= 1'b0;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end
endmodule
